uart_rx: RTL



---
 rtl/uart_rx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Resynchronises rx, detects the start edge, takes a
// 2-of-3 majority vote around mid-bit and presents each good byte with a
// one-cycle po_flag strobe. A low stop bit raises a one-cycle frame_err and
// parks the FSM in BREAK until the line returns high.
module uart_rx #(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err
);

    localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
    localparam logic [15:0] MID          = 16'(BAUD_CNT_MAX / 2);
    localparam logic [15:0] MID_M1       = MID - 16'd1;
    localparam logic [15:0] MID_P1       = MID + 16'd1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state;
    logic        rx_reg1, rx_reg2, rx_reg3;
    logic [1:0]  fill;
    logic        armed;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        samp_a, samp_b;
    logic        maj;
    logic        baud_wrap;
    logic        samp_pt;

    // Three-flop synchroniser; idles high so reset looks like an idle line.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_reg1 <= 1'b1;
            rx_reg2 <= 1'b1;
            rx_reg3 <= 1'b1;
        end else begin
            rx_reg1 <= rx;
            rx_reg2 <= rx_reg1;
            rx_reg3 <= rx_reg2;
        end
    end

    // Arm start detection only once the line has really been seen high.
    // The synchroniser resets to 1, so without this a line that is low at
    // reset release would fake a 1->0 edge. fill marks when rx_reg2 first
    // carries a genuine pin sample rather than its reset value.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            fill <= {fill[0], 1'b1};
            if (fill[1] && rx_reg2)
                armed <= 1'b1;
        end
    end

    // Capture the two early votes; the third is rx_reg2 itself at MID+1.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            samp_a <= 1'b0;
            samp_b <= 1'b0;
        end else if (state != IDLE) begin
            if (baud_cnt == MID_M1)
                samp_a <= rx_reg2;
            if (baud_cnt == MID)
                samp_b <= rx_reg2;
        end
    end

    assign maj       = (samp_a & samp_b) | (samp_a & rx_reg2) | (samp_b & rx_reg2);
    assign baud_wrap = (baud_cnt == BAUD_LAST);
    assign samp_pt   = (baud_cnt == MID_P1);

    // Frame FSM with baud/bit counters, shift register and registered strobes.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            po_data   <= 8'h00;
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= 16'd0;
                    bit_cnt  <= 4'd0;
                    if (armed && rx_reg3 && !rx_reg2)
                        state <= START;
                end
                START: begin
                    baud_cnt <= baud_wrap ? 16'd0 : baud_cnt + 16'd1;
                    if (samp_pt && maj) begin
                        // Glitch shorter than half a bit: not a real start.
                        state    <= IDLE;
                        baud_cnt <= 16'd0;
                    end else if (baud_wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    baud_cnt <= baud_wrap ? 16'd0 : baud_cnt + 16'd1;
                    if (samp_pt) begin
                        shreg   <= {maj, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    if (baud_wrap && bit_cnt == 4'd8)
                        state <= STOP;
                end
                STOP: begin
                    baud_cnt <= baud_wrap ? 16'd0 : baud_cnt + 16'd1;
                    if (samp_pt) begin
                        // Decide at mid-stop so the next start edge is caught
                        // even with zero idle time or a slightly fast sender.
                        baud_cnt <= 16'd0;
                        if (maj) begin
                            po_data <= shreg;
                            po_flag <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    baud_cnt <= 16'd0;
                    if (rx_reg2)
                        state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= 16'd0;
                end
            endcase
        end
    end

endmodule
